// File: rtl/cpu_decode_scoreboard.sv
// Register-hazard scoreboard and issue interlock for the decode stage.
// Tracks outstanding register writes, blocks RAW/WAW hazards and caps in-flight writes.
module cpu_decode_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int MAX_INFLIGHT = 4,
  parameter int STALL_CNT_W  = 16,
  localparam int INFL_W      = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [REG_ADDR_W-1:0]  issue_src1,
  input  logic                   issue_src1_used,
  input  logic [REG_ADDR_W-1:0]  issue_src2,
  input  logic                   issue_src2_used,
  input  logic [REG_ADDR_W-1:0]  issue_dst,
  input  logic                   issue_dst_used,
  input  logic                   flush,
  input  logic                   wb_valid,
  input  logic [REG_ADDR_W-1:0]  wb_addr,
  output logic [NUM_REGS-1:0]    pending,
  output logic [INFL_W-1:0]      inflight,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   wb_error
);

  // Handshake: an instruction is accepted in a cycle where issue_valid and issue_ready
  // are both high; while valid is high and ready low, decode holds all issue_* stable.

  logic [NUM_REGS-1:0]    pending_q;
  logic [INFL_W-1:0]      inflight_q;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   wb_error_q;

  logic [NUM_REGS-1:0]    clr_mask;
  logic [NUM_REGS-1:0]    set_mask;
  logic [NUM_REGS-1:0]    eff_mask;
  logic [NUM_REGS-1:0]    pending_d;
  logic                   src1_hit;
  logic                   src2_hit;
  logic                   dst_hit;
  logic                   hazard;
  logic                   legal_wb;
  logic                   full;
  logic                   dst_nz;
  logic                   accept;
  logic                   write_issue;
  logic                   stall_cycle;

  always_comb begin
    clr_mask = '0;
    if (wb_valid) clr_mask[wb_addr] = 1'b1;
  end

  // A writeback landing this cycle already satisfies the hazard (bypass).
  assign eff_mask = pending_q & ~clr_mask;

  assign src1_hit = issue_src1_used & (issue_src1 != '0) & eff_mask[issue_src1];
  assign src2_hit = issue_src2_used & (issue_src2 != '0) & eff_mask[issue_src2];
  assign dst_hit  = issue_dst_used  & (issue_dst  != '0) & eff_mask[issue_dst];
  assign hazard   = src1_hit | src2_hit | dst_hit;

  assign legal_wb = wb_valid & (wb_addr != '0) & pending_q[wb_addr];
  assign full     = (inflight_q == INFL_W'(MAX_INFLIGHT)) & ~legal_wb;
  assign dst_nz   = issue_dst_used & (issue_dst != '0);

  assign issue_ready = ~flush & ~hazard & ~(dst_nz & full);
  assign accept      = issue_valid & issue_ready;
  assign write_issue = accept & dst_nz;
  assign stall_cycle = issue_valid & ~issue_ready & ~flush;

  always_comb begin
    set_mask = '0;
    if (write_issue) set_mask[issue_dst] = 1'b1;
  end

  // Set is OR-ed in after the clear, so a same-register set/clear keeps the bit.
  assign pending_d = (pending_q & ~clr_mask) | set_mask;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q  <= '0;
      inflight_q <= '0;
      stall_q    <= '0;
      wb_error_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      case ({write_issue, legal_wb})
        2'b10:   inflight_q <= inflight_q + INFL_W'(1);
        2'b01:   inflight_q <= inflight_q - INFL_W'(1);
        default: inflight_q <= inflight_q;
      endcase
      if (stall_cycle && !(&stall_q)) stall_q <= stall_q + STALL_CNT_W'(1);
      if (wb_valid && !legal_wb) wb_error_q <= 1'b1;
    end
  end

  assign pending     = pending_q;
  assign inflight    = inflight_q;
  assign stall_count = stall_q;
  assign wb_error    = wb_error_q;

endmodule

// File: tb/tb_cpu_decode_scoreboard.sv
// Bench for cpu_decode_scoreboard: directed scenarios plus random traffic against a
// register-set reference model, checked through an expectation queue by a monitor.
module tb_cpu_decode_scoreboard;

  localparam int NR   = 32;
  localparam int AW   = 5;
  localparam int MAXI = 4;
  localparam int SW   = 4;
  localparam int IW   = 3;
  localparam int EW   = 1 + NR + IW + SW + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic [AW-1:0] issue_src1 = '0;
  logic          issue_src1_used = 1'b0;
  logic [AW-1:0] issue_src2 = '0;
  logic          issue_src2_used = 1'b0;
  logic [AW-1:0] issue_dst = '0;
  logic          issue_dst_used = 1'b0;
  logic          flush = 1'b0;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [NR-1:0] pending;
  logic [IW-1:0] inflight;
  logic [SW-1:0] stall_count;
  logic          wb_error;

  cpu_decode_scoreboard #(
    .NUM_REGS(NR), .REG_ADDR_W(AW), .MAX_INFLIGHT(MAXI), .STALL_CNT_W(SW)
  ) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_src1(issue_src1), .issue_src1_used(issue_src1_used),
    .issue_src2(issue_src2), .issue_src2_used(issue_src2_used),
    .issue_dst(issue_dst), .issue_dst_used(issue_dst_used),
    .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .pending(pending), .inflight(inflight), .stall_count(stall_count),
    .wb_error(wb_error)
  );

  // clock / reset
  always #5 clock = ~clock;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model: set of registers with an outstanding write
  bit m_pend[NR];
  int m_stall = 0;
  bit m_err = 1'b0;
  bit last_rdy = 1'b0;

  function automatic bit blocked(int r, bit wv, int wa);
    return (r != 0) && m_pend[r] && !(wv && (wa == r));
  endfunction

  // driver: applies one cycle of inputs, pushes what the DUT must show in that cycle
  task automatic step(input bit rst_v, input bit v,
                      input int s1, input bit s1u, input int s2, input bit s2u,
                      input int d, input bit du, input bit fl,
                      input bit wv, input int wa);
    bit legal, haz, full, rdy;
    int cnt;
    logic [NR-1:0] pv;
    reset = rst_v;
    issue_valid = v;
    issue_src1 = AW'(s1); issue_src1_used = s1u;
    issue_src2 = AW'(s2); issue_src2_used = s2u;
    issue_dst = AW'(d);   issue_dst_used = du;
    flush = fl;
    wb_valid = wv; wb_addr = AW'(wa);
    if (!rst_v) begin
      for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
      m_stall = 0;
      m_err = 1'b0;
    end
    cnt = 0;
    pv = '0;
    for (int i = 0; i < NR; i++) if (m_pend[i]) begin cnt++; pv[i] = 1'b1; end
    legal = wv && (wa != 0) && m_pend[wa];
    haz = (s1u && blocked(s1, wv, wa)) || (s2u && blocked(s2, wv, wa)) ||
          (du && blocked(d, wv, wa));
    full = (cnt == MAXI) && !legal;
    if (!rst_v) rdy = !fl;
    else rdy = !fl && !haz && !(du && (d != 0) && full);
    exp_q.push_back({rdy, pv, IW'(cnt), SW'(m_stall), m_err});
    if (rst_v) begin
      if (v && !rdy && !fl && m_stall < (1 << SW) - 1) m_stall++;
      if (wv && !legal) m_err = 1'b1;
      if (legal) m_pend[wa] = 1'b0;
      if (v && rdy && du && d != 0) m_pend[d] = 1'b1;
    end
    last_rdy = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wb(input int r);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // monitor: compares every expectation in the cycle it describes
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("issue_ready", 32'(issue_ready), 32'(e[EW-1]));
        chk("pending", 32'(pending), 32'(e[EW-2 -: NR]));
        chk("inflight", 32'(inflight), 32'(e[SW+IW : SW+1]));
        chk("stall_count", 32'(stall_count), 32'(e[SW:1]));
        chk("wb_error", 32'(wb_error), 32'(e[0]));
      end
    end
  end

  initial begin
    bit hv, hs1u, hs2u, hdu, fl, wv;
    int hs1, hs2, hd, wa;
    int plist[$];
    @(posedge clock);
    #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // RAW on r3, unblocked by a same-cycle writeback
    step(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    repeat (3) step(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 1, 0, 0, 0, 0, 0, 1, 3);
    idle(1);

    // WAW on r5 with bypassed re-issue
    step(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 5, 1, 0, 1, 5);
    idle(1);
    wb(5);

    // capacity limit
    for (int r = 1; r <= 4; r++) step(1, 1, 0, 0, 0, 0, r, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 6, 1, 0, 1, 1);
    idle(1);
    wb(2); wb(3); wb(4); wb(6);

    // register 0 never pending; writeback to it is an error
    step(1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    wb(0);
    idle(1);

    // flush blocks acceptance and leaves pending intact
    step(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 8, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0, 8, 1, 0, 0, 0);
    idle(1);

    // reset with two writes outstanding; stale writeback afterwards
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8, 1, 0, 0, 7, 1, 0, 0, 0);
    wb(8);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // random traffic
    hv = 0; hs1 = 0; hs2 = 0; hd = 0; hs1u = 0; hs2u = 0; hdu = 0;
    for (int c = 0; c < 600; c++) begin
      if (!(hv && !last_rdy)) begin
        hv   = ($urandom_range(0, 3) != 0);
        hs1  = int'($urandom_range(0, 7));
        hs2  = int'($urandom_range(0, 7));
        hd   = int'($urandom_range(0, 7));
        hs1u = 1'($urandom_range(0, 1));
        hs2u = 1'($urandom_range(0, 1));
        hdu  = ($urandom_range(0, 3) != 0);
      end
      fl = ($urandom_range(0, 15) == 0);
      wv = 1'b0;
      wa = 0;
      if ($urandom_range(0, 2) == 0) begin
        plist.delete();
        for (int i = 0; i < NR; i++) if (m_pend[i]) plist.push_back(i);
        if (plist.size() > 0) begin
          wv = 1'b1;
          wa = plist[$urandom_range(0, plist.size() - 1)];
        end
      end else if ($urandom_range(0, 59) == 0) begin
        wv = 1'b1;
        wa = int'($urandom_range(0, 31));
      end
      step((c != 300), hv, hs1, hs1u, hs2, hs2u, hd, hdu, fl, wv, wa);
    end
    idle(2);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clock);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
